// File: rtl/lsu_mmio.sv
// lsu_mmio: single-cycle memory-mapped I/O slave for the load/store unit.
// Holds LED/HEX/LCD output registers, synchronizes switch and button inputs,
// and keeps sticky write-1-to-clear rising-edge flags for the buttons.
module lsu_mmio #(
  parameter int NUM_HEX = 8,
  parameter int NUM_BTN = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lsu_req,
  input  logic                 i_lsu_wren,
  input  logic [31:0]          i_lsu_addr,
  input  logic [1:0]           i_lsu_size,
  input  logic                 i_lsu_unsigned,
  input  logic [31:0]          i_st_data,
  output logic [31:0]          o_ld_data,
  output logic                 o_lsu_ack,
  output logic                 o_lsu_err,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [NUM_HEX*7-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd,
  input  logic [31:0]          i_io_sw,
  input  logic [NUM_BTN-1:0]   i_io_btn
);
  // word addresses (byte address >> 2)
  localparam logic [29:0] WA_LEDR  = 30'h0000_1C00;
  localparam logic [29:0] WA_LEDG  = 30'h0000_1C04;
  localparam logic [29:0] WA_HEX0  = 30'h0000_1C08;
  localparam logic [29:0] WA_LCD   = 30'h0000_1C10;
  localparam logic [29:0] WA_SW    = 30'h0000_1E00;
  localparam logic [29:0] WA_BTN   = 30'h0000_1E04;
  localparam logic [29:0] WA_BEDGE = 30'h0000_1E05;

  logic [31:0]              ledr, ledg, lcd;
  logic [NUM_HEX-1:0][6:0]  hex;
  logic [31:0]              sw_s1, sw_s2;
  logic [NUM_BTN-1:0]       btn_s1, btn_s2, btn_s3, btn_edge;
  logic [1:0]               prime;

  logic [29:0]              wa;
  logic [1:0]               off;
  logic                     misal, we;
  logic [3:0]               be;
  logic [31:0]              wmask, wdata, rword, sh, ld_val;
  logic [NUM_BTN-1:0]       clr, rise;

  assign wa    = i_lsu_addr[31:2];
  assign off   = i_lsu_addr[1:0];
  assign wdata = i_st_data << {off, 3'b000};
  assign we    = i_lsu_req & i_lsu_wren & ~misal;

  // Alignment check and byte-lane enables for the current access
  always_comb begin
    misal = 1'b0;
    be    = 4'b0000;
    unique case (i_lsu_size)
      2'b00: be = 4'b0001 << off;
      2'b01: begin be = 4'b0011 << off; misal = off[0]; end
      2'b10: begin be = 4'b1111; misal = (off != 2'b00); end
      default: misal = 1'b1;
    endcase
  end

  // Expand lane enables to a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{be[i]}};
  end

  // Read mux: unmapped words read as zero
  always_comb begin
    rword = '0;
    if (wa == WA_LEDR)  rword = ledr;
    if (wa == WA_LEDG)  rword = ledg;
    if (wa == WA_LCD)   rword = lcd;
    if (wa == WA_SW)    rword = sw_s2;
    if (wa == WA_BTN)   rword = 32'(btn_s2);
    if (wa == WA_BEDGE) rword = 32'(btn_edge);
    for (int k = 0; k < NUM_HEX; k++)
      if (wa == WA_HEX0 + 30'(k)) rword = {25'd0, hex[k]};
  end

  // Extract the addressed byte/half and extend it
  always_comb begin
    sh = rword >> {off, 3'b000};
    unique case (i_lsu_size)
      2'b00:   ld_val = i_lsu_unsigned ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ld_val = i_lsu_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld_val = sh;
    endcase
  end

  // Edge flags: W1C on enabled lanes; rises only count once the
  // synchronizer chain holds post-reset samples, so a button held through
  // reset does not look like a press.
  always_comb begin
    clr = '0;
    if (we && wa == WA_BEDGE)
      for (int i = 0; i < NUM_BTN; i++) clr[i] = wdata[i] & wmask[i];
    rise = btn_s2 & ~btn_s3 & {NUM_BTN{prime == 2'd3}};
  end

  // Writable output registers, merged per byte lane
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      hex  <= '0;
    end else begin
      if (we && wa == WA_LEDR) ledr <= (ledr & ~wmask) | (wdata & wmask);
      if (we && wa == WA_LEDG) ledg <= (ledg & ~wmask) | (wdata & wmask);
      if (we && wa == WA_LCD)  lcd  <= (lcd  & ~wmask) | (wdata & wmask);
      for (int k = 0; k < NUM_HEX; k++)
        if (we && wa == WA_HEX0 + 30'(k) && be[0]) hex[k] <= i_st_data[6:0];
    end
  end

  // Input synchronizers, previous-value flop and sticky edge flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_s3   <= '0;
      btn_edge <= '0;
      prime    <= '0;
    end else begin
      sw_s1    <= i_io_sw;
      sw_s2    <= sw_s1;
      btn_s1   <= i_io_btn;
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      btn_edge <= (btn_edge & ~clr) | rise;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  // Response: ack one cycle after every request, load data held between acks
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_lsu_ack <= 1'b0;
      o_lsu_err <= 1'b0;
      o_ld_data <= '0;
    end else begin
      o_lsu_ack <= i_lsu_req;
      o_lsu_err <= i_lsu_req & misal;
      if (i_lsu_req) o_ld_data <= (misal || i_lsu_wren) ? 32'd0 : ld_val;
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex  = hex;

endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio: directed stimulus, byte-level behavioural model checked every
// cycle, plus literal expectations at the interesting points.
module tb_lsu_mmio;
  localparam int NH = 4;
  localparam int NB = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req = 1'b0, wren = 1'b0, uns = 1'b0;
  logic [31:0]   addr = '0, st = '0, sw_in = '0;
  logic [1:0]    size = '0;
  logic [NB-1:0] btn = '0;
  logic [31:0]   ld, ledr, ledg, lcd;
  logic          ack, err;
  logic [NH*7-1:0] hex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mmio #(.NUM_HEX(NH), .NUM_BTN(NB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_req(req), .i_lsu_wren(wren),
    .i_lsu_addr(addr), .i_lsu_size(size), .i_lsu_unsigned(uns),
    .i_st_data(st), .o_ld_data(ld), .o_lsu_ack(ack), .o_lsu_err(err),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd),
    .i_io_sw(sw_in), .i_io_btn(btn)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0]   m_ledr, m_ledg, m_lcd, m_ld;
  logic [6:0]    m_hex [NH];
  logic [NB-1:0] m_flags;
  logic [31:0]   swh [1:3];
  logic [NB-1:0] bh [1:3];
  int            n_post;
  logic          m_ack, m_err;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w;
    int idx;
    w = {a[31:2], 2'b00};
    if (w == 32'h7000) return m_ledr;
    if (w == 32'h7010) return m_ledg;
    if (w == 32'h7040) return m_lcd;
    if (w == 32'h7800) return swh[2];
    if (w == 32'h7810) return 32'(bh[2]);
    if (w == 32'h7814) return 32'(m_flags);
    if (w >= 32'h7020 && w < 32'h7020 + 4*NH) begin
      idx = int'((w - 32'h7020) >> 2);
      return {25'd0, m_hex[idx]};
    end
    return 32'd0;
  endfunction

  // Model update from pre-edge inputs, then compare just after the edge
  always @(posedge clk) begin
    logic [31:0]   a, w, v, wa32;
    logic [7:0]    by;
    logic [NB-1:0] clr, set;
    logic [NH*7-1:0] hexp;
    int nb, off, ln;
    logic mis;
    clr = '0;
    if (!rst_n) begin
      m_ledr = 0; m_ledg = 0; m_lcd = 0; m_ld = 0; m_flags = 0;
      for (int k = 0; k < NH; k++) m_hex[k] = 0;
      for (int j = 1; j <= 3; j++) begin swh[j] = 0; bh[j] = 0; end
      n_post = 0; m_ack = 0; m_err = 0;
    end else begin
      a    = addr;
      wa32 = {a[31:2], 2'b00};
      off  = int'(a[1:0]);
      nb   = 1 << size;
      mis  = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
      m_ack = req;
      m_err = req && mis;
      if (req) begin
        if (mis || wren) m_ld = 0;
        if (!mis && wren) begin
          for (int b = 0; b < nb; b++) begin
            ln = off + b;
            by = st[8*b +: 8];
            case (wa32)
              32'h7000: m_ledr[8*ln +: 8] = by;
              32'h7010: m_ledg[8*ln +: 8] = by;
              32'h7040: m_lcd[8*ln +: 8]  = by;
              32'h7814: if (ln == 0) clr = by[NB-1:0];
              default:
                if (wa32 >= 32'h7020 && wa32 < 32'h7020 + 4*NH && ln == 0)
                  m_hex[int'((wa32 - 32'h7020) >> 2)] = by[6:0];
            endcase
          end
        end
        if (!mis && !wren) begin
          w = m_word(a);
          v = 0;
          for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
          if (!uns && nb < 4 && v[8*nb-1])
            for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
          m_ld = v;
        end
      end
      set = (n_post >= 3) ? (bh[2] & ~bh[3]) : '0;
      m_flags = (m_flags & ~clr) | set;
      swh[3] = swh[2]; swh[2] = swh[1]; swh[1] = sw_in;
      bh[3]  = bh[2];  bh[2]  = bh[1];  bh[1]  = btn;
      if (n_post < 100) n_post++;
    end
    #1;
    for (int k = 0; k < NH; k++) hexp[7*k +: 7] = m_hex[k];
    chk("ack", 32'(ack), 32'(m_ack));
    chk("err", 32'(err), 32'(m_err));
    chk("ld_data", ld, m_ld);
    chk("ledr", ledr, m_ledr);
    chk("ledg", ledg, m_ledg);
    chk("lcd", lcd, m_lcd);
    chk("hex", 32'(hex), 32'(hexp));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic acc(input logic w, input logic [31:0] a, input logic [1:0] s,
                     input logic u, input logic [31:0] d);
    req = 1'b1; wren = w; addr = a; size = s; uns = u; st = d;
    @(negedge clk);
    req = 1'b0; wren = 1'b0;
  endtask

  initial begin
    // reset with a request pending and a button held high
    req = 1'b1; btn = 4'b0001;
    cyc(3);
    rst_n = 1'b1; req = 1'b0;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ld", ld, 32'd0);
    chk("rst_ledr", ledr, 32'd0);
    cyc(1);
    chk("no_ack_after_rst", 32'(ack), 32'd0);
    cyc(4);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("held_btn_no_edge", ld, 32'd0);
    acc(0, 32'h7810, 2'd2, 0, 0); chk("btn_sync", ld, 32'd1);
    btn = 4'b0000;

    acc(1, 32'h7000, 2'd2, 0, 32'hDEADBEEF);
    chk("sw_ledr", ledr, 32'hDEADBEEF);
    chk("sw_ack", 32'(ack), 32'd1);
    acc(0, 32'h7000, 2'd2, 0, 0);
    chk("lw_ledr", ld, 32'hDEADBEEF);
    chk("lw_ack", 32'(ack), 32'd1);

    acc(1, 32'h7003, 2'd0, 0, 32'h80);
    acc(0, 32'h7003, 2'd0, 0, 0); chk("lb", ld, 32'hFFFFFF80);
    acc(0, 32'h7003, 2'd0, 1, 0); chk("lbu", ld, 32'h00000080);
    chk("sb_lanes", ledr, 32'h80ADBEEF);

    acc(1, 32'h7001, 2'd1, 0, 32'h1234);
    chk("sh_mis_err", 32'(err), 32'd1);
    chk("sh_mis_keep", ledr, 32'h80ADBEEF);
    acc(0, 32'h7004, 2'd2, 0, 0);
    chk("unmapped_ld", ld, 32'd0);
    chk("unmapped_err", 32'(err), 32'd0);
    acc(0, 32'h7002, 2'd1, 0, 0); chk("lh", ld, 32'hFFFF80AD);
    acc(0, 32'h7000, 2'd1, 1, 0); chk("lhu", ld, 32'h0000BEEF);
    acc(0, 32'h7000, 2'd3, 0, 0);
    chk("size11_err", 32'(err), 32'd1);
    chk("size11_ld", ld, 32'd0);

    acc(1, 32'h7010, 2'd2, 0, 32'h12345678);
    acc(0, 32'h7011, 2'd0, 0, 0); chk("ledg_lb", ld, 32'h00000056);
    acc(1, 32'h7042, 2'd1, 0, 32'h0000ABCD);
    chk("lcd_sh", lcd, 32'hABCD0000);

    acc(1, 32'h702C, 2'd2, 0, 32'h7F);
    chk("hex3", 32'(hex[27:21]), 32'h7F);
    acc(1, 32'h7030, 2'd2, 0, 32'hFFFFFFFF);
    acc(0, 32'h7030, 2'd2, 0, 0);
    chk("hex4_ld", ld, 32'd0);
    chk("hex4_err", 32'(err), 32'd0);
    acc(1, 32'h7020, 2'd2, 0, 32'hFFFFFFFF);
    acc(0, 32'h7020, 2'd2, 0, 0); chk("hex0_7bit", ld, 32'h7F);

    sw_in = 32'hCAFEF00D;
    cyc(2);
    acc(0, 32'h7800, 2'd2, 0, 0); chk("sw_read", ld, 32'hCAFEF00D);
    acc(1, 32'h7800, 2'd2, 0, 32'h0);
    chk("ro_store_err", 32'(err), 32'd0);
    acc(0, 32'h7800, 2'd2, 0, 0); chk("ro_store_keep", ld, 32'hCAFEF00D);

    btn = 4'b0100;
    cyc(3);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("edge2", ld, 32'h4);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("edge_read_keeps", ld, 32'h4);
    acc(1, 32'h7814, 2'd2, 0, 32'h4);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("w1c", ld, 32'h0);

    btn = 4'b0110;
    cyc(3);
    acc(1, 32'h7815, 2'd0, 0, 32'hFF);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("w1c_lane_off", ld, 32'h2);

    btn = 4'b0111;
    cyc(2);
    acc(1, 32'h7814, 2'd2, 0, 32'h3);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("set_wins", ld, 32'h1);

    // reset with a load in flight
    req = 1'b1; wren = 1'b0; addr = 32'h7000; size = 2'd2; rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b1;
    chk("rst2_ack", 32'(ack), 32'd0);
    chk("rst2_ledr", ledr, 32'd0);
    cyc(1);
    chk("rst2_no_ack", 32'(ack), 32'd0);
    cyc(4);
    acc(0, 32'h7814, 2'd2, 0, 0); chk("rst2_no_edge", ld, 32'd0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mmio.md
LSU_MMIO -- requirements
Module: lsu_mmio

Interface
REQ-001 SHALL have parameter NUM_HEX, default 8, meaning the number of 7-segment registers (1..8).
REQ-002 SHALL have parameter NUM_BTN, default 4, meaning the button input width (1..32).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_lsu_req, input, 1 bit: access request valid.
REQ-006 SHALL have port i_lsu_wren, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port i_lsu_addr, input, 32 bits: byte address.
REQ-008 SHALL have port i_lsu_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port i_lsu_unsigned, input, 1 bit: zero-extend a load (1) or sign-extend it (0).
REQ-010 SHALL have port i_st_data, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port o_ld_data, output, 32 bits: registered load data.
REQ-012 SHALL have port o_lsu_ack, output, 1 bit: access complete.
REQ-013 SHALL have port o_lsu_err, output, 1 bit: misaligned or illegal-size access; valid with o_lsu_ack.
REQ-014 SHALL have ports o_io_ledr and o_io_ledg, outputs, 32 bits each: LED registers.
REQ-015 SHALL have port o_io_hex, output, NUM_HEX*7 bits: digit k on bits [7k+6:7k].
REQ-016 SHALL have port o_io_lcd, output, 32 bits: LCD register.
REQ-017 SHALL have port i_io_sw, input, 32 bits: asynchronous switch inputs.
REQ-018 SHALL have port i_io_btn, input, NUM_BTN bits: asynchronous button inputs, active-high.

Function
REQ-019 Address map (word address = addr[31:2]) SHALL be:
- LEDR 0x7000, LEDG 0x7010: RW
- HEXk 0x7020+4k for k < NUM_HEX: RW, bits [6:0] stored, upper bits read 0
- LCD 0x7040: RW
- SW 0x7800: RO, synchronized
- BTN 0x7810: RO, synchronized, zero-extended
- BTN_EDGE 0x7814: sticky rising-edge flags, write-1-to-clear
REQ-020 Every cycle with i_lsu_req=1 SHALL be accepted; o_lsu_ack SHALL pulse exactly one cycle later; back-to-back requests SHALL produce back-to-back acks.
REQ-021 Stores SHALL update the register on the accepting clock edge, using byte lanes selected by addr[1:0] and size; unwritten lanes SHALL be kept.
REQ-022 Loads SHALL extract the addressed byte or half and sign- or zero-extend it; o_ld_data SHALL be registered and valid while o_lsu_ack=1, and SHALL hold its value otherwise.
REQ-023 An access SHALL be misaligned when it is half with addr[0]=1, word with addr[1:0]≠0, or size=11.
REQ-024 A misaligned access SHALL write nothing and SHALL acknowledge with o_lsu_err=1 and o_ld_data=0.
REQ-025 Unmapped addresses SHALL load 0, ignore stores, and set o_lsu_err=0.
REQ-026 Stores to RO registers SHALL be ignored without error.
REQ-027 i_io_sw and i_io_btn SHALL pass through 2-flop synchronizers; loads SHALL return the synchronized values (2-cycle input latency).
REQ-028 A BTN_EDGE[i] flag SHALL set when the synchronized btn[i] goes 0→1 (a third flop provides the previous value).
REQ-029 If an edge and a W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-030 Reading BTN_EDGE SHALL NOT clear it.
REQ-031 A store to BTN_EDGE SHALL apply W1C only on its enabled byte lanes.
REQ-032 Outputs o_io_* SHALL be driven directly from the registers, with no extra delay.

Reset
REQ-033 On a rising i_clk edge with i_rst_n=0, all registers, synchronizer flops and edge flags SHALL clear to 0, and o_lsu_ack, o_lsu_err and o_ld_data SHALL be 0.
REQ-034 A request in flight during reset SHALL be dropped, with no ack after reset.
REQ-035 Edge flags SHALL NOT set from a synchronized button already high when reset releases.

Verification
REQ-036 SW to LEDR 0x7000 with data 0xDEADBEEF → o_io_ledr=0xDEADBEEF next cycle; a following LW returns 0xDEADBEEF with ack 1 cycle after the request.
REQ-037 SB of 0x80 to 0x7003, then LB 0x7003 → 0xFFFFFF80; LBU → 0x00000080; LEDR bytes [2:0] unchanged.
REQ-038 SH to 0x7001 → ack with err=1; LEDR unchanged.
REQ-039 LW 0x7004 → ack, data 0, err=0.
REQ-040 btn[2] driven 0→1 → BTN_EDGE reads 0x4 from the 3rd cycle on; SW 0x4 to 0x7814 → reads 0.
REQ-041 A new edge coincident with a W1C → flag stays 1.
REQ-042 With NUM_HEX=4, SW 0x7F to 0x702C → o_io_hex[27:21]=0x7F; SW to 0x7030 → ignored; LW 0x7030 → 0.
